async_operator_fifo: RTL and testbench

- Next-generation dataflow node for the arf graphs: same req/ack pull protocol as the existing async_operator.
- Operands are captured synchronously; there is no edge-triggered capture on ack.
- Results are buffered in a DEPTH-entry FIFO, so upstream can run ahead of slow consumers.
- Fan-out of OUTPUT_SIZE consumers is served independently; each FIFO entry retires only after every consumer has taken it once.
- Replaces reg chains plus operator nodes wherever slack is needed.

---
 rtl/async_pkg.sv | 27 ++
 rtl/fifo_fanout.sv | 75 +++++++
 rtl/async_operator_fifo.sv | 112 +++++++++++
 tb/tb_async_operator_fifo.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_pkg.sv
// Shared definitions for the arf async dataflow nodes: operator codes,
// the protocol-error flag value and an elaboration-time clog2.
package async_pkg;

    localparam int OP_REG  = 0;
    localparam int OP_IN   = 1;
    localparam int OP_OUT  = 2;
    localparam int OP_ADDI = 3;
    localparam int OP_SUBI = 4;
    localparam int OP_MULI = 5;
    localparam int OP_ADD  = 6;
    localparam int OP_SUB  = 7;
    localparam int OP_MUL  = 8;
    localparam int OP_BAD  = 15;

    localparam logic ERR_PROTOCOL = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_fanout.sv
// Result FIFO with independent fan-out: the head entry is offered to every
// consumer once and retires only when all of them have taken it.
module fifo_fanout
    import async_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int output_size = 1,
    parameter int depth       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [data_width-1:0]        push_data,
    input  logic [output_size-1:0]       req_r,
    output logic [output_size-1:0]       ack_r,
    output logic [data_width-1:0]        dout,
    output logic [clog2(depth+1)-1:0]    count,
    output logic                         empty,
    output logic                         full
);
    localparam int PW = clog2(depth);
    localparam int CW = clog2(depth + 1);

    logic [data_width-1:0]  mem_q [depth];
    logic [data_width-1:0]  mem_d [depth];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [output_size-1:0] served_q, served_d, ack_q, ack_d;
    logic                   retire;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        retire   = &served_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (retire) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !retire)      count_d = count_q + 1'b1;
        else if (!push && retire) count_d = count_q - 1'b1;
        // The ack_q term forces a gap cycle so each ack is a single-cycle pulse.
        for (int j = 0; j < output_size; j++) begin
            ack_d[j] = req_r[j] & ~served_q[j] & ~ack_q[j] & (count_q != '0);
        end
        served_d = retire ? '0 : (served_q | ack_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < depth; k++) mem_q[k] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            served_q <= '0;
            ack_q    <= '0;
        end else begin
            for (int k = 0; k < depth; k++) mem_q[k] <= mem_d[k];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            served_q <= served_d;
            ack_q    <= ack_d;
        end
    end

    assign ack_r = ack_q;
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(depth));

endmodule

// File: rtl/async_operator_fifo.sv
// Dataflow operator node: captures operands over req/ack, computes the
// result and pushes it into a fan-out FIFO for downstream consumers.
module async_operator_fifo
    import async_pkg::*;
#(
    parameter int    data_width  = 32,
    parameter string op          = "add",
    parameter int    immediate   = 0,
    parameter int    input_size  = 2,
    parameter int    output_size = 1,
    parameter int    depth       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [input_size-1:0]            req_l,
    input  logic [input_size-1:0]            ack_l,
    input  logic [data_width*input_size-1:0] din,
    input  logic [output_size-1:0]           req_r,
    output logic [output_size-1:0]           ack_r,
    output logic [data_width-1:0]            dout,
    output logic [clog2(depth+1)-1:0]        count,
    output logic                             empty,
    output logic                             full,
    output logic                             err
);
    localparam int OPC = (op == "reg")  ? OP_REG  :
                         (op == "in")   ? OP_IN   :
                         (op == "out")  ? OP_OUT  :
                         (op == "addi") ? OP_ADDI :
                         (op == "subi") ? OP_SUBI :
                         (op == "muli") ? OP_MULI :
                         (op == "add")  ? OP_ADD  :
                         (op == "sub")  ? OP_SUB  :
                         (op == "mul")  ? OP_MUL  : OP_BAD;
    localparam logic [data_width-1:0] IMM = data_width'(immediate);

    if (OPC == OP_BAD || (OPC <= OP_MULI && input_size != 1) ||
        (OPC >= OP_ADD && (input_size < 2 || input_size > 3))) begin : g_bad_op
        $error("async_operator_fifo: unsupported op/input_size combination");
    end
    if (output_size < 1 || output_size > 4 || depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_shape
        $error("async_operator_fifo: bad output_size or depth");
    end

    logic [data_width-1:0] opnd_q [input_size];
    logic [data_width-1:0] opnd_d [input_size];
    logic [input_size-1:0] has_q, has_d, req_l_q, req_l_d;
    logic                  err_q, err_d;
    logic                  fire, fifo_full;
    logic [data_width-1:0] result;

    // Left-to-right evaluation: opnd0 op opnd1 op opnd2.
    always_comb begin
        result = opnd_q[0];
        case (OPC)
            OP_ADDI: result = opnd_q[0] + IMM;
            OP_SUBI: result = opnd_q[0] - IMM;
            OP_MULI: result = opnd_q[0] * IMM;
            OP_ADD:  for (int i = 1; i < input_size; i++) result = result + opnd_q[i];
            OP_SUB:  for (int i = 1; i < input_size; i++) result = result - opnd_q[i];
            OP_MUL:  for (int i = 1; i < input_size; i++) result = result * opnd_q[i];
            default: result = opnd_q[0];
        endcase
    end

    always_comb begin
        fire  = (&has_q) & ~fifo_full;
        err_d = err_q;
        for (int i = 0; i < input_size; i++) begin
            opnd_d[i] = (ack_l[i] && !has_q[i]) ? din[i*data_width +: data_width] : opnd_q[i];
            has_d[i]  = fire ? 1'b0 : (has_q[i] | ack_l[i]);
        end
        if (|(ack_l & has_q)) err_d = ERR_PROTOCOL;
        req_l_d = ~has_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < input_size; i++) opnd_q[i] <= '0;
            has_q   <= '0;
            req_l_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < input_size; i++) opnd_q[i] <= opnd_d[i];
            has_q   <= has_d;
            req_l_q <= req_l_d;
            err_q   <= err_d;
        end
    end

    fifo_fanout #(
        .data_width (data_width),
        .output_size(output_size),
        .depth      (depth)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fire),
        .push_data(result),
        .req_r    (req_r),
        .ack_r    (ack_r),
        .dout     (dout),
        .count    (count),
        .empty    (empty),
        .full     (fifo_full)
    );

    assign full  = fifo_full;
    assign req_l = req_l_q;
    assign err   = err_q;

endmodule

// File: tb/tb_async_operator_fifo.sv
// Bench for async_operator_fifo: four configurations (add, addi, reg fan-out, sub3)
// sharing one clock and reset, with per-consumer expected-result queues.
module tb_async_operator_fifo;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [1:0]  req_l_a, ack_l_a;
    logic [63:0] din_a;
    logic [0:0]  req_r_a, ack_r_a;
    logic [31:0] dout_a;
    logic [2:0]  count_a;
    logic        empty_a, full_a, err_a;

    logic [0:0]  req_l_b, ack_l_b;
    logic [31:0] din_b;
    logic [0:0]  req_r_b, ack_r_b;
    logic [31:0] dout_b;
    logic [2:0]  count_b;
    logic        empty_b, full_b, err_b;

    logic [0:0]  req_l_c, ack_l_c;
    logic [31:0] din_c;
    logic [1:0]  req_r_c, ack_r_c;
    logic [31:0] dout_c;
    logic [2:0]  count_c;
    logic        empty_c, full_c, err_c;

    logic [2:0]  req_l_d, ack_l_d;
    logic [95:0] din_d;
    logic [0:0]  req_r_d, ack_r_d;
    logic [31:0] dout_d;
    logic [2:0]  count_d;
    logic        empty_d, full_d, err_d;

    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic [31:0] exp_c0_q[$];
    logic [31:0] exp_c1_q[$];
    logic [31:0] exp_d_q[$];
    int          n_ack_c0, n_ack_c1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;
    vec_t vecs[8];

    async_operator_fifo #(.data_width(32), .op("add"), .input_size(2), .output_size(1), .depth(4)) dut_a (
        .clk(clk), .rst(rst), .req_l(req_l_a), .ack_l(ack_l_a), .din(din_a), .req_r(req_r_a),
        .ack_r(ack_r_a), .dout(dout_a), .count(count_a), .empty(empty_a), .full(full_a), .err(err_a));

    async_operator_fifo #(.data_width(32), .op("addi"), .immediate(2), .input_size(1), .output_size(1), .depth(4)) dut_b (
        .clk(clk), .rst(rst), .req_l(req_l_b), .ack_l(ack_l_b), .din(din_b), .req_r(req_r_b),
        .ack_r(ack_r_b), .dout(dout_b), .count(count_b), .empty(empty_b), .full(full_b), .err(err_b));

    async_operator_fifo #(.data_width(32), .op("reg"), .input_size(1), .output_size(2), .depth(4)) dut_c (
        .clk(clk), .rst(rst), .req_l(req_l_c), .ack_l(ack_l_c), .din(din_c), .req_r(req_r_c),
        .ack_r(ack_r_c), .dout(dout_c), .count(count_c), .empty(empty_c), .full(full_c), .err(err_c));

    async_operator_fifo #(.data_width(32), .op("sub"), .input_size(3), .output_size(1), .depth(4)) dut_d (
        .clk(clk), .rst(rst), .req_l(req_l_d), .ack_l(ack_l_d), .din(din_d), .req_r(req_r_d),
        .ack_r(ack_r_d), .dout(dout_d), .count(count_d), .empty(empty_d), .full(full_d), .err(err_d));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard monitors: pop an expected value on every consumer ack
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_r_a[0]) begin
                if (exp_a_q.size() == 0) chk("a_unexpected_ack", 1, 0);
                else chk("a_dout", {32'h0, dout_a}, {32'h0, exp_a_q.pop_front()});
            end
            if (ack_r_b[0]) begin
                if (exp_b_q.size() == 0) chk("b_unexpected_ack", 1, 0);
                else chk("b_dout", {32'h0, dout_b}, {32'h0, exp_b_q.pop_front()});
            end
            if (ack_r_c[0]) begin
                n_ack_c0++;
                if (exp_c0_q.size() == 0) chk("c0_unexpected_ack", 1, 0);
                else chk("c0_dout", {32'h0, dout_c}, {32'h0, exp_c0_q.pop_front()});
            end
            if (ack_r_c[1]) begin
                n_ack_c1++;
                if (exp_c1_q.size() == 0) chk("c1_unexpected_ack", 1, 0);
                else chk("c1_dout", {32'h0, dout_c}, {32'h0, exp_c1_q.pop_front()});
            end
            if (ack_r_d[0]) begin
                if (exp_d_q.size() == 0) chk("d_unexpected_ack", 1, 0);
                else chk("d_dout", {32'h0, dout_d}, {32'h0, exp_d_q.pop_front()});
            end
        end
    end

    function automatic int pending();
        return exp_a_q.size() + exp_b_q.size() + exp_c0_q.size() + exp_c1_q.size() + exp_d_q.size();
    endfunction

    // driver tasks
    task automatic drain(input string name);
        int t;
        t = 0;
        while (pending() != 0 && t < 200) begin
            tick();
            t++;
        end
        chk(name, pending(), 0);
    endtask

    task automatic wait_req_a(input logic [1:0] want);
        int t;
        t = 0;
        while (req_l_a !== want && t < 50) begin
            tick();
            t++;
        end
        if (req_l_a !== want) chk("a_req_timeout", {62'h0, req_l_a}, {62'h0, want});
    endtask

    task automatic drive_a(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        wait_req_a(2'b11);
        din_a   = {b, a};
        ack_l_a = 2'b11;
        exp_a_q.push_back(exp);
        tick();
        ack_l_a = 2'b00;
    endtask

    task automatic drive_b(input logic [31:0] v);
        int t;
        t = 0;
        while (req_l_b !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (req_l_b !== 1'b1) chk("b_req_timeout", {63'h0, req_l_b}, 1);
        din_b   = v;
        ack_l_b = 1'b1;
        exp_b_q.push_back(v + 32'd2);
        tick();
        ack_l_b = 1'b0;
    endtask

    initial begin
        int t;
        total    = 0;
        bad      = 0;
        n_ack_c0 = 0;
        n_ack_c1 = 0;
        ack_l_a = '0; din_a = '0; req_r_a = '0;
        ack_l_b = '0; din_b = '0; req_r_b = '0;
        ack_l_c = '0; din_c = '0; req_r_c = '0;
        ack_l_d = '0; din_d = '0; req_r_d = '0;

        vecs[0] = '{32'd0, 32'd0, 32'd0};
        vecs[1] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'd0};
        vecs[3] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
        for (int i = 4; i < 8; i++) begin
            vecs[i].a   = $urandom_range(32'h7FFF_FFFF, 0);
            vecs[i].b   = $urandom_range(32'h7FFF_FFFF, 0);
            vecs[i].sum = vecs[i].a + vecs[i].b;
        end

        rst = 1'b0;
        #1 rst = 1'b1;
        tick(2);
        chk("rst_req_l", {62'h0, req_l_a}, 0);
        chk("rst_count", {61'h0, count_a}, 0);
        chk("rst_empty", {63'h0, empty_a}, 1);
        chk("rst_full", {63'h0, full_a}, 0);
        chk("rst_err", {63'h0, err_a}, 0);
        chk("rst_dout", {32'h0, dout_a}, 0);
        chk("rst_ack_r", {63'h0, ack_r_a}, 0);
        rst = 1'b0;
        tick();
        chk("req_l_after_release", {62'h0, req_l_a}, 2'b11);

        // add latency: capture edge, fire edge, ack edge, retire edge
        req_r_a = 1'b1;
        din_a   = {32'd5, 32'd3};
        ack_l_a = 2'b11;
        exp_a_q.push_back(32'd8);
        tick();
        ack_l_a = 2'b00;
        chk("lat_req_l_low", {62'h0, req_l_a}, 0);
        chk("lat_count0", {61'h0, count_a}, 0);
        tick();
        chk("lat_count1", {61'h0, count_a}, 1);
        chk("lat_req_l_high", {62'h0, req_l_a}, 2'b11);
        chk("lat_no_ack_yet", {63'h0, ack_r_a}, 0);
        tick();
        chk("lat_ack", {63'h0, ack_r_a}, 1);
        chk("lat_dout", {32'h0, dout_a}, 32'd8);
        tick();
        chk("lat_ack_drop", {63'h0, ack_r_a}, 0);
        chk("lat_count_end", {61'h0, count_a}, 0);
        chk("lat_empty_end", {63'h0, empty_a}, 1);

        for (int i = 0; i < 8; i++) drive_a(vecs[i].a, vecs[i].b, vecs[i].sum);
        drain("a_table_drain");

        // duplicate ack on operand 0 must be ignored and flagged
        wait_req_a(2'b11);
        din_a[31:0] = 32'd40;
        ack_l_a     = 2'b01;
        tick();
        ack_l_a = 2'b00;
        chk("err_req_l_partial", {62'h0, req_l_a}, 2'b10);
        chk("err_clear_before", {63'h0, err_a}, 0);
        din_a[31:0] = 32'd99;
        ack_l_a     = 2'b01;
        tick();
        ack_l_a = 2'b00;
        chk("err_set", {63'h0, err_a}, 1);
        din_a[63:32] = 32'd2;
        ack_l_a      = 2'b10;
        exp_a_q.push_back(32'd42);
        tick();
        ack_l_a = 2'b00;
        drain("err_result_drain");
        chk("err_sticky", {63'h0, err_a}, 1);

        // addi with idle consumer: fill to full, fifth operand parked
        for (int v = 0; v < 5; v++) drive_b(v);
        tick(3);
        chk("b_count_full", {61'h0, count_b}, 4);
        chk("b_full", {63'h0, full_b}, 1);
        chk("b_req_l_parked", {63'h0, req_l_b}, 0);
        req_r_b = 1'b1;
        drain("b_drain");
        tick(2);
        chk("b_count_end", {61'h0, count_b}, 0);
        chk("b_req_l_end", {63'h0, req_l_b}, 1);

        // fan-out: consumer 1 late, head must wait for it
        req_r_c = 2'b01;
        t = 0;
        while (req_l_c !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        din_c   = 32'd7;
        ack_l_c = 1'b1;
        exp_c0_q.push_back(32'd7);
        exp_c1_q.push_back(32'd7);
        tick();
        ack_l_c = 1'b0;
        tick(10);
        chk("c_c0_one_ack", n_ack_c0, 1);
        chk("c_c1_none", n_ack_c1, 0);
        chk("c_head_held", {61'h0, count_c}, 1);
        req_r_c = 2'b11;
        t = 0;
        while (n_ack_c1 == 0 && t < 20) begin
            tick();
            t++;
        end
        chk("c_c1_acked", n_ack_c1, 1);
        tick(2);
        chk("c_retired", {61'h0, count_c}, 0);
        chk("c_c0_still_one", n_ack_c0, 1);
        chk("c_empty", {63'h0, empty_c}, 1);

        // three-operand sub, left to right
        req_r_d = 1'b1;
        t = 0;
        while (req_l_d !== 3'b111 && t < 50) begin
            tick();
            t++;
        end
        din_d   = {32'd20, 32'd3, 32'd10};
        ack_l_d = 3'b111;
        exp_d_q.push_back(32'hFFFF_FFF3);
        tick();
        ack_l_d = 3'b000;
        drain("d_drain");

        // async reset mid-operation with three entries queued
        req_r_a = 1'b0;
        drive_a(32'd1, 32'd1, 32'd2);
        drive_a(32'd2, 32'd2, 32'd4);
        drive_a(32'd3, 32'd3, 32'd6);
        tick(2);
        chk("pre_rst_count", {61'h0, count_a}, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", {61'h0, count_a}, 0);
        chk("mid_rst_empty", {63'h0, empty_a}, 1);
        chk("mid_rst_ack_r", {63'h0, ack_r_a}, 0);
        chk("mid_rst_req_l", {62'h0, req_l_a}, 0);
        chk("mid_rst_err", {63'h0, err_a}, 0);
        chk("mid_rst_dout", {32'h0, dout_a}, 0);
        exp_a_q.delete();
        #2 rst = 1'b0;
        req_r_a = 1'b1;
        tick();
        chk("post_rst_req_l", {62'h0, req_l_a}, 2'b11);
        chk("post_rst_req_l_d", {61'h0, req_l_d}, 3'b111);
        tick(5);
        chk("post_rst_no_ack", {63'h0, ack_r_a}, 0);
        chk("final_pending", pending(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
